// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_div_pkg;

    localparam int unsigned SEQ_DIV_WIDTH = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor always holds, so shifted < 2*divisor and the top bit of the
    // WIDTH+1-bit difference is a reliable borrow flag.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, MSB first.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_DIV_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [CW-1:0]    cnt;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (prem),
        .bit_in  (work[WIDTH-1]),
        .divisor (dsr),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Control FSM and datapath registers; work shifts dividend bits out at the top
    // while quotient bits enter at the bottom, ending up holding the full quotient.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            work        <= '0;
            dsr         <= '0;
            prem        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor != '0) begin
                            work        <= dividend;
                            dsr         <= divisor;
                            prem        <= '0;
                            cnt         <= CW'(WIDTH - 1);
                            div_by_zero <= 1'b0;
                            state       <= CALC;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                CALC: begin
                    work <= {work[WIDTH-2:0], step_q};
                    prem <= step_rem;
                    cnt  <= cnt - CW'(1);
                    if (cnt == '0) begin
                        quotient  <= {work[WIDTH-2:0], step_q};
                        remainder <= step_rem;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL provide parameter WIDTH, default 18: operand, quotient and remainder width in bits.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1: synchronous active-high reset.
REQ-005 SHALL have port start, input, 1: request a division, accepted only in IDLE.
REQ-006 SHALL have port dividend, input, WIDTH: unsigned dividend, sampled on an accepted start.
REQ-007 SHALL have port divisor, input, WIDTH: unsigned divisor, sampled on an accepted start.
REQ-008 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-009 SHALL have port done, output, 1: single-cycle pulse marking valid results.
REQ-010 SHALL have port quotient, output, WIDTH: result quotient.
REQ-011 SHALL have port remainder, output, WIDTH: result remainder.
REQ-012 SHALL have port div_by_zero, output, 1: flags that the last result came from divisor == 0.

Function
REQ-013 SHALL implement a restoring unsigned divider that resolves one quotient bit per cycle, MSB first.
REQ-014 SHALL use a state machine with states IDLE, CALC and DONE.
REQ-015 SHALL, in IDLE with start=1 and divisor!=0: register both operands, clear the partial remainder, load the iteration counter with WIDTH-1, and go to CALC.
REQ-016 SHALL, in IDLE with start=1 and divisor==0: go straight to DONE and set quotient to all ones, remainder to dividend, and div_by_zero to 1.
REQ-017 SHALL, in each CALC cycle:
- shift the next dividend bit into the partial remainder;
- trial-subtract the divisor, using a WIDTH+1-bit difference so the borrow is detected;
- on no borrow, keep the difference and write quotient bit 1; on borrow, restore and write 0;
- decrement the counter.
REQ-018 SHALL leave CALC for DONE after the iteration with counter 0, so CALC lasts exactly WIDTH cycles.
REQ-019 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-020 SHALL give a latency of WIDTH+1 cycles from the start-sampling edge to done (19 for WIDTH=18), or 1 cycle for divide-by-zero.
REQ-021 SHALL clear div_by_zero on every accepted start with divisor!=0.
REQ-022 SHALL hold quotient, remainder and div_by_zero stable from done until the next accepted start.
REQ-023 SHALL ignore start while busy=1; operands must not be resampled.
REQ-024 SHALL make start=1 in the DONE cycle have no effect; a new request needs start in a later IDLE cycle.
REQ-025 SHALL guarantee, for every divisor!=0, that dividend == quotient*divisor + remainder and remainder < divisor.

Reset
REQ-026 SHALL, on RST=1 at a clock edge, go to IDLE and clear busy, done, quotient, remainder, div_by_zero and the counter.
REQ-027 SHALL let RST override start and abort any division in progress, with no done pulse for the aborted operation.
REQ-028 SHALL accept start on the first edge after RST deasserts.

Structure
REQ-029 SHALL take the state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default WIDTH from a shared package, seq_div_pkg.
REQ-030 SHALL place the combinational shift/trial-subtract/restore step in one sub-module, div_step, instanced once.

Verification (WIDTH=18)
REQ-031 SHALL cover: start, 100/7 -> done at cycle 19, quotient=14, remainder=2, div_by_zero=0.
REQ-032 SHALL cover: 0x3FFFF/1 -> quotient=0x3FFFF, remainder=0; then 3/10 -> quotient=0, remainder=3.
REQ-033 SHALL cover: 5/0 -> done at cycle 1, quotient=0x3FFFF, remainder=5, div_by_zero=1; a following 9/3 -> quotient=3, div_by_zero=0.
REQ-034 SHALL cover: 1000/9 started, then start with 50/5 at cycle 5 -> second start ignored; result 111 r 1 at cycle 19.
REQ-035 SHALL cover: RST at cycle 8 of 1000/9 -> busy=0 next cycle, no done pulse, all outputs 0; a new 20/6 -> 3 r 2.
REQ-036 SHALL cover: 10k random operand pairs checked against REQ-025 and the fixed latency.
